// File: rtl/s2m_stream_fifo.sv
// s2m_stream_fifo: Avalon-MM write slave feeding a first-word-fall-through Avalon-ST source.
// Define S2M_FIFO_PACKET_EN to store per-word startofpacket/endofpacket markers.
module s2m_stream_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 32,
  parameter int CHANNEL_WIDTH = 8,
  parameter int ERROR_WIDTH   = 8,
  parameter int ALMOST_FULL   = DEPTH - 4
) (
  input  logic                     wrclock,
  input  logic                     reset,
  input  logic [1:0]               avalonmm_slave_address,
  input  logic                     avalonmm_slave_write,
  input  logic [DATA_WIDTH-1:0]    avalonmm_slave_writedata,
  input  logic                     avalonmm_slave_read,
  output logic [DATA_WIDTH-1:0]    avalonmm_slave_readdata,
  output logic                     avalonmm_slave_readdatavalid,
  output logic                     avalonmm_slave_waitrequest,
  output logic [DATA_WIDTH-1:0]    avalonst_source_data,
  output logic [CHANNEL_WIDTH-1:0] avalonst_source_channel,
  output logic [ERROR_WIDTH-1:0]   avalonst_source_error,
`ifdef S2M_FIFO_PACKET_EN
  output logic                     avalonst_source_startofpacket,
  output logic                     avalonst_source_endofpacket,
`endif
  output logic                     avalonst_source_valid,
  input  logic                     avalonst_source_ready,
  output logic                     almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef S2M_FIFO_PACKET_EN
  localparam int EW = DATA_WIDTH + CHANNEL_WIDTH + ERROR_WIDTH + 2;
`else
  localparam int EW = DATA_WIDTH + CHANNEL_WIDTH + ERROR_WIDTH;
`endif
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_AF   = LW'(ALMOST_FULL);

  logic [EW-1:0]            mem [DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [LW-1:0]            level;
  logic [CHANNEL_WIDTH-1:0] sb_channel;
  logic [ERROR_WIDTH-1:0]   sb_error;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic                     sb_write;
  logic [EW-1:0]            wr_entry;
  logic [EW-1:0]            head;
  logic [DATA_WIDTH-1:0]    rd_mux;
  logic                     unused_wdata;

  assign full     = (level == LEVEL_FULL);
  assign empty    = (level == '0);
  assign sb_write = avalonmm_slave_write && (avalonmm_slave_address == 2'd1);
  assign push     = avalonmm_slave_write && (avalonmm_slave_address == 2'd0) && !full;
  assign pop      = !empty && avalonst_source_ready;

  assign avalonmm_slave_waitrequest = reset ||
      (avalonmm_slave_write && (avalonmm_slave_address == 2'd0) && full);

  // Valid comes only from the registered level, never from ready.
  assign avalonst_source_valid = !empty;
  assign head                  = mem[rd_ptr];
  assign unused_wdata          = ^avalonmm_slave_writedata;

`ifdef S2M_FIFO_PACKET_EN
  logic sb_sop;
  logic sb_eop;

  assign wr_entry = {sb_eop, sb_sop, sb_error, sb_channel, avalonmm_slave_writedata};
  assign {avalonst_source_endofpacket, avalonst_source_startofpacket,
          avalonst_source_error, avalonst_source_channel, avalonst_source_data} = head;

  // Markers are one-shot: consumed by the next accepted data push.
  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      sb_sop <= 1'b0;
      sb_eop <= 1'b0;
    end else if (sb_write) begin
      sb_sop <= avalonmm_slave_writedata[0];
      sb_eop <= avalonmm_slave_writedata[1];
    end else if (push) begin
      sb_sop <= 1'b0;
      sb_eop <= 1'b0;
    end
  end
`else
  assign wr_entry = {sb_error, sb_channel, avalonmm_slave_writedata};
  assign {avalonst_source_error, avalonst_source_channel, avalonst_source_data} = head;
`endif

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      sb_channel <= '0;
      sb_error   <= '0;
    end else if (sb_write) begin
      sb_channel <= avalonmm_slave_writedata[8 +: CHANNEL_WIDTH];
      sb_error   <= avalonmm_slave_writedata[16 +: ERROR_WIDTH];
    end
  end

  always_ff @(posedge wrclock) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      almost_full <= (level >= LEVEL_AF);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avalonmm_slave_address)
      2'd2:    rd_mux = DATA_WIDTH'(level);
      2'd3:    rd_mux[2:0] = {almost_full, full, empty};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge wrclock or posedge reset) begin
    if (reset) begin
      avalonmm_slave_readdata      <= '0;
      avalonmm_slave_readdatavalid <= 1'b0;
    end else begin
      avalonmm_slave_readdatavalid <= avalonmm_slave_read;
      if (avalonmm_slave_read) avalonmm_slave_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_s2m_stream_fifo.sv
// Scoreboard bench for s2m_stream_fifo (DEPTH 32, ALMOST_FULL 28); packet checks
// run only when S2M_FIFO_PACKET_EN is defined.
module tb_s2m_stream_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic [31:0] st_data;
  logic [7:0]  st_channel;
  logic [7:0]  st_error;
  logic        valid;
  logic        ready = 1'b0;
  logic        af;
  logic [49:0] head_act;

  int vectors = 0;
  int miscompares = 0;
  logic [49:0] sb[$];
  logic [7:0]  mdl_ch = '0;
  logic [7:0]  mdl_err = '0;
  logic        mdl_sop = 1'b0;
  logic        mdl_eop = 1'b0;

  always #5 clk = ~clk;

`ifdef S2M_FIFO_PACKET_EN
  logic st_sop;
  logic st_eop;
  assign head_act = {st_eop, st_sop, st_error, st_channel, st_data};
`else
  assign head_act = {2'b00, st_error, st_channel, st_data};
`endif

  s2m_stream_fifo #(
    .DATA_WIDTH(32), .DEPTH(32), .CHANNEL_WIDTH(8), .ERROR_WIDTH(8), .ALMOST_FULL(28)
  ) dut (
    .wrclock                      (clk),
    .reset                        (reset),
    .avalonmm_slave_address       (address),
    .avalonmm_slave_write         (write),
    .avalonmm_slave_writedata     (writedata),
    .avalonmm_slave_read          (read),
    .avalonmm_slave_readdata      (readdata),
    .avalonmm_slave_readdatavalid (readdatavalid),
    .avalonmm_slave_waitrequest   (waitrequest),
    .avalonst_source_data         (st_data),
    .avalonst_source_channel      (st_channel),
    .avalonst_source_error        (st_error),
`ifdef S2M_FIFO_PACKET_EN
    .avalonst_source_startofpacket(st_sop),
    .avalonst_source_endofpacket  (st_eop),
`endif
    .avalonst_source_valid        (valid),
    .avalonst_source_ready        (ready),
    .almost_full                  (af)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] d);
    sb.push_back({mdl_eop, mdl_sop, mdl_err, mdl_ch, d});
    mdl_sop = 1'b0;
    mdl_eop = 1'b0;
  endtask

  task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
    int n = 0;
    address = a; writedata = d; write = 1'b1;
    #1;
    while (waitrequest && n < 64) begin
      tick();
      n++;
    end
    if (n == 64) begin
      vectors++; miscompares++;
      $display("FAIL write_timeout addr %0d stalled %0d cycles, required < 64", a, n);
    end
    if (a == 2'd0) sb_push(d);
    else if (a == 2'd1) begin
      mdl_ch  = d[15:8];
      mdl_err = d[23:16];
`ifdef S2M_FIFO_PACKET_EN
      mdl_sop = d[0];
      mdl_eop = d[1];
`endif
    end
    tick();
    write = 1'b0;
  endtask

  task automatic mm_read(input logic [1:0] a, output logic rdv, output logic [31:0] d);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
    rdv = readdatavalid;
    d = readdata;
  endtask

  task automatic test_reset();
    logic rdv;
    logic [31:0] rd;
    repeat (2) tick();
    vectors++; if (waitrequest !== 1'b1) begin miscompares++; $display("FAIL reset_waitrequest got %b required 1", waitrequest); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b required 0", valid); end
    vectors++; if (af !== 1'b0) begin miscompares++; $display("FAIL reset_almost_full got %b required 0", af); end
    vectors++; if (readdatavalid !== 1'b0 || readdata !== 32'd0) begin miscompares++; $display("FAIL reset_readdata got %b/%h required 0/0", readdatavalid, readdata); end
    reset = 1'b0;
    tick();
    vectors++; if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL release_waitrequest got %b required 0", waitrequest); end
    mm_read(2'd2, rdv, rd);
    vectors++; if (rdv !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL reset_level got %b/%h required 1/0", rdv, rd); end
    mm_read(2'd3, rdv, rd);
    vectors++; if (rdv !== 1'b1 || rd !== 32'h1) begin miscompares++; $display("FAIL reset_status got %b/%h required 1/1", rdv, rd); end
  endtask

  task automatic test_first_word();
    mm_write(2'd1, 32'h0003_0500);
    mm_write(2'd0, 32'hA5A5_0001);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL first_valid got %b required 1", valid); end
    vectors++; if (st_data !== 32'hA5A5_0001) begin miscompares++; $display("FAIL first_data got %h required a5a50001", st_data); end
    vectors++; if (st_channel !== 8'h05 || st_error !== 8'h03) begin miscompares++; $display("FAIL first_sideband got %h/%h required 05/03", st_channel, st_error); end
    ready = 1'b1;
    vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL first_pop got %h required %h", head_act, sb[0]); end
    void'(sb.pop_front());
    tick();
    ready = 1'b0;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL first_empty got %b required 0", valid); end
  endtask

  task automatic test_full();
    logic rdv;
    logic [31:0] rd;
    ready = 1'b0;
    for (int i = 0; i < 32; i++) mm_write(2'd0, 32'h1000_0000 + i);
    mm_read(2'd2, rdv, rd);
    vectors++; if (rdv !== 1'b1 || rd !== 32'd32) begin miscompares++; $display("FAIL full_level got %b/%0d required 1/32", rdv, rd); end
    mm_read(2'd3, rdv, rd);
    vectors++; if (rd !== 32'h6) begin miscompares++; $display("FAIL full_status got %h required 6", rd); end
    address = 2'd3; writedata = '1; write = 1'b1;
    #1;
    vectors++; if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL full_ctrl_write got %b required 0", waitrequest); end
    tick();
    write = 1'b0;
    mm_read(2'd2, rdv, rd);
    vectors++; if (rd !== 32'd32) begin miscompares++; $display("FAIL ignored_write_level got %0d required 32", rd); end
    address = 2'd0; writedata = 32'h1000_0020; write = 1'b1;
    #1;
    vectors++; if (waitrequest !== 1'b1) begin miscompares++; $display("FAIL full_push_stall got %b required 1", waitrequest); end
    ready = 1'b1;
    #1;
    vectors++; if (waitrequest !== 1'b1) begin miscompares++; $display("FAIL full_pop_push_stall got %b required 1", waitrequest); end
    vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL full_head0 got %h required %h", head_act, sb[0]); end
    void'(sb.pop_front());
    tick();
    vectors++; if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL stalled_push_accept got %b required 0", waitrequest); end
    sb_push(32'h1000_0020);
    vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL full_head1 got %h required %h", head_act, sb[0]); end
    void'(sb.pop_front());
    tick();
    write = 1'b0;
    for (int n = 0; n < 80 && sb.size() > 0; n++) begin
      if (valid) begin
        vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL full_drain got %h required %h", head_act, sb[0]); end
        void'(sb.pop_front());
      end
      tick();
    end
    ready = 1'b0;
    vectors++; if (sb.size() != 0 || valid !== 1'b0) begin miscompares++; $display("FAIL full_drain_end left %0d valid %b required 0 0", sb.size(), valid); end
  endtask

  task automatic test_almost_full();
    ready = 1'b0;
    for (int i = 0; i < 27; i++) begin
      mm_write(2'd0, 32'h2000_0000 + i);
      vectors++; if (af !== 1'b0) begin miscompares++; $display("FAIL af_below level %0d got %b required 0", i + 1, af); end
    end
    tick();
    vectors++; if (af !== 1'b0) begin miscompares++; $display("FAIL af_level27 got %b required 0", af); end
    mm_write(2'd0, 32'h2000_001B);
    vectors++; if (af !== 1'b0) begin miscompares++; $display("FAIL af_lag got %b required 0", af); end
    tick();
    vectors++; if (af !== 1'b1) begin miscompares++; $display("FAIL af_set got %b required 1", af); end
    ready = 1'b1;
    vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL af_pop got %h required %h", head_act, sb[0]); end
    void'(sb.pop_front());
    tick();
    ready = 1'b0;
    vectors++; if (af !== 1'b1) begin miscompares++; $display("FAIL af_clear_lag got %b required 1", af); end
    tick();
    vectors++; if (af !== 1'b0) begin miscompares++; $display("FAIL af_clear got %b required 0", af); end
    ready = 1'b1;
    for (int n = 0; n < 80 && sb.size() > 0; n++) begin
      if (valid) begin
        vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL af_drain got %h required %h", head_act, sb[0]); end
        void'(sb.pop_front());
      end
      tick();
    end
    ready = 1'b0;
    vectors++; if (sb.size() != 0 || valid !== 1'b0) begin miscompares++; $display("FAIL af_drain_end left %0d valid %b required 0 0", sb.size(), valid); end
  endtask

  task automatic test_back_to_back();
    logic rdv;
    logic [31:0] rd;
    mm_write(2'd1, 32'h0007_0900);
    mm_write(2'd0, 32'h3000_0000);
    ready = 1'b1; write = 1'b1; address = 2'd0;
    for (int i = 1; i <= 10; i++) begin
      writedata = 32'h3000_0000 + i;
      vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid cycle %0d got %b required 1", i, valid); end
      vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL b2b_order cycle %0d got %h required %h", i, head_act, sb[0]); end
      void'(sb.pop_front());
      sb_push(writedata);
      #1;
      vectors++; if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL b2b_stall cycle %0d got %b required 0", i, waitrequest); end
      tick();
    end
    write = 1'b0; ready = 1'b0;
    mm_read(2'd2, rdv, rd);
    vectors++; if (rd !== 32'd1) begin miscompares++; $display("FAIL b2b_level got %0d required 1", rd); end
    vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL b2b_last got %h required %h", head_act, sb[0]); end
    void'(sb.pop_front());
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

`ifdef S2M_FIFO_PACKET_EN
  task automatic test_packet();
    mm_write(2'd1, 32'h0002_0301);
    mm_write(2'd0, 32'hAAAA_0000);
    mm_write(2'd0, 32'hBBBB_0000);
    mm_write(2'd1, 32'h0002_0302);
    mm_write(2'd0, 32'hCCCC_0000);
    ready = 1'b1;
    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      if (valid) begin
        vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL pkt_word got %h required %h", head_act, sb[0]); end
        void'(sb.pop_front());
      end
      tick();
    end
    ready = 1'b0;
    vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL pkt_drain_end left %0d required 0", sb.size()); end
  endtask
`endif

  task automatic test_reset_mid_drain();
    logic rdv;
    logic [31:0] rd;
    for (int i = 0; i < 6; i++) mm_write(2'd0, 32'h4000_0000 + i);
    ready = 1'b1;
    vectors++; if (head_act !== sb[0]) begin miscompares++; $display("FAIL mid_pop got %h required %h", head_act, sb[0]); end
    void'(sb.pop_front());
    tick();
    reset = 1'b1;
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid got %b required 0", valid); end
    vectors++; if (waitrequest !== 1'b1) begin miscompares++; $display("FAIL mid_reset_waitrequest got %b required 1", waitrequest); end
    sb.delete();
    mdl_ch = '0; mdl_err = '0; mdl_sop = 1'b0; mdl_eop = 1'b0;
    ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mm_read(2'd2, rdv, rd);
    vectors++; if (rdv !== 1'b1 || rd !== 32'd0) begin miscompares++; $display("FAIL mid_level got %b/%0d required 1/0", rdv, rd); end
    mm_read(2'd3, rdv, rd);
    vectors++; if (rd !== 32'h1) begin miscompares++; $display("FAIL mid_status got %h required 1", rd); end
    mm_write(2'd0, 32'h5A5A_0042);
    vectors++; if (valid !== 1'b1 || head_act !== sb[0]) begin miscompares++; $display("FAIL mid_first got %b/%h required 1/%h", valid, head_act, sb[0]); end
    void'(sb.pop_front());
    ready = 1'b1;
    tick();
    ready = 1'b0;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_final_empty got %b required 0", valid); end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_full();
    test_almost_full();
    test_back_to_back();
`ifdef S2M_FIFO_PACKET_EN
    test_packet();
`endif
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion before 200000");
    $fatal(1);
  end

endmodule
